// File: rtl/efi_result_buffer.sv
// efi_result_buffer
// Store-and-forward burst buffer between the efi_trig results stream and the
// fCore efi_results input. One burst (terminated by tlast) is captured in full,
// then replayed in arrival order, so the core never sees a partial or stalled
// burst. Beats beyond DEPTH are dropped and flagged by a sticky overflow bit.
//
// Optional build macro EFI_RESULT_BUFFER_STATS_EN adds the bursts_done and
// beats_dropped statistics outputs; core behaviour is identical either way.
module efi_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic [DEST_WIDTH-1:0]     in_dest,
    input  logic [USER_WIDTH-1:0]     in_user,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [DEST_WIDTH-1:0]     out_dest,
    output logic [USER_WIDTH-1:0]     out_user,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    input  logic                      clear_overflow,
    output logic [$clog2(DEPTH):0]    burst_length
`ifdef EFI_RESULT_BUFFER_STATS_EN
    ,
    output logic [31:0]               bursts_done,
    output logic [15:0]               beats_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_DEPTH = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DISCARD = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                state_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic [WW-1:0]         out_word_reg;
    logic                  overflow_reg;
    logic [LW-1:0]         burst_length_reg;

    // Beat storage: {data, dest, user} per entry, no reset so it maps to RAM.
    logic [WW-1:0]         mem [DEPTH];

    logic                  in_fire;
    logic                  ovf_set;
    logic [AW-1:0]         rd_ptr_inc;
    logic [AW-1:0]         rd_addr;
    logic [WW-1:0]         rd_word;

    assign in_fire    = in_valid && in_ready_reg;
    // The beat that fills the last slot without tlast starts the discard phase.
    assign ovf_set    = (state_reg == FILL) && in_fire && !in_last && (wr_ptr_reg == PTR_LAST);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    // While a beat is presented, prefetch the next one so replay runs at 1 beat/cycle.
    assign rd_addr    = out_valid_reg ? rd_ptr_inc : rd_ptr_reg;
    assign rd_word    = mem[rd_addr];

    // Capture accepted beats while filling.
    always_ff @(posedge clock) begin
        if ((state_reg == FILL) && in_fire) begin
            mem[wr_ptr_reg] <= {in_data, in_dest, in_user};
        end
    end

    // Capture/discard/drain state machine with registered handshake and payload outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= FILL;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            in_ready_reg     <= 1'b1;
            out_valid_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
            out_word_reg     <= '0;
            overflow_reg     <= 1'b0;
            burst_length_reg <= '0;
        end else begin
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end

            case (state_reg)
                FILL: begin
                    if (in_fire) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (in_last) begin
                            state_reg        <= DRAIN;
                            in_ready_reg     <= 1'b0;
                            rd_ptr_reg       <= '0;
                            burst_length_reg <= {1'b0, wr_ptr_reg} + LEN_ONE;
                        end else if (wr_ptr_reg == PTR_LAST) begin
                            state_reg        <= DISCARD;
                            burst_length_reg <= LEN_DEPTH;
                        end
                    end
                end

                DISCARD: begin
                    if (in_fire && in_last) begin
                        state_reg    <= DRAIN;
                        in_ready_reg <= 1'b0;
                        rd_ptr_reg   <= '0;
                    end
                end

                DRAIN: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_word_reg  <= rd_word;
                        out_last_reg  <= (burst_length_reg == LEN_ONE);
                    end else if (out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= FILL;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            wr_ptr_reg    <= '0;
                            rd_ptr_reg    <= '0;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            rd_ptr_reg   <= rd_ptr_inc;
                            out_word_reg <= rd_word;
                            out_last_reg <= ({1'b0, rd_ptr_inc} == (burst_length_reg - LEN_ONE));
                        end
                    end
                end

                default: begin
                    state_reg    <= FILL;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_last     = out_last_reg;
    assign {out_data, out_dest, out_user} = out_word_reg;
    assign overflow     = overflow_reg;
    assign burst_length = burst_length_reg;

`ifdef EFI_RESULT_BUFFER_STATS_EN
    logic [31:0] bursts_done_reg;
    logic [15:0] beats_dropped_reg;

    // Completed-replay counter (wrapping) and dropped-beat counter (saturating).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bursts_done_reg   <= '0;
            beats_dropped_reg <= '0;
        end else if (clear_overflow) begin
            bursts_done_reg   <= '0;
            beats_dropped_reg <= '0;
        end else begin
            if ((state_reg == DRAIN) && out_valid_reg && out_ready && out_last_reg) begin
                bursts_done_reg <= bursts_done_reg + 1'b1;
            end
            if ((state_reg == DISCARD) && in_fire && (beats_dropped_reg != 16'hFFFF)) begin
                beats_dropped_reg <= beats_dropped_reg + 1'b1;
            end
        end
    end

    assign bursts_done   = bursts_done_reg;
    assign beats_dropped = beats_dropped_reg;
`endif

endmodule
